// File: rtl/dmem_pkg.sv
// Shared types and helpers for the LSQ-facing data memory.
package dmem_pkg;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Store byte enables; misaligned or non-store encodings enable nothing.
    function automatic logic [3:0] store_byte_en(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return lane[0] ? 4'b0000 : (4'b0011 << lane);
            F3_W:    return (lane == 2'b00) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    // A store is misaligned when its legal size does not fit the lane offset.
    function automatic logic store_misalign(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_H:    return lane[0];
            F3_W:    return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_extract.sv
// Combinational lane select, sign/zero extension and misalign detection.
module dmem_load_extract
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[8*lane +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    // Pick and extend the addressed lane; misaligned and illegal encodings return zero.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            F3_B:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H: begin
                if (lane[0]) misalign = 1'b1;
                else         data = {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                if (lane[0]) misalign = 1'b1;
                else         data = {{(XLEN-16){1'b0}}, half_sel};
            end
            F3_W: begin
                if (lane != 2'b00) misalign = 1'b1;
                else               data = word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsq_port.sv
// Byte-addressed little-endian data memory serving speculative loads,
// committed stores and commit-time load re-checks.
module dmem_lsq_port
    import dmem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 2048,
    parameter int ADDR_W      = 32,
    parameter int TAG_W       = 6,
    parameter int INIT_OFFSET = 3
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [2:0]        ld_req_funct3,
    input  logic [TAG_W-1:0]  ld_req_tag,
    output logic              ld_rsp_valid,
    output logic [XLEN-1:0]   ld_rsp_data,
    output logic [TAG_W-1:0]  ld_rsp_tag,
    output logic              ld_rsp_misalign,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [2:0]        st_funct3,
    input  logic [XLEN-1:0]   st_data,
    output logic              st_misalign,
    input  logic              chk_valid,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [2:0]        chk_funct3,
    input  logic [XLEN-1:0]   chk_data,
    output logic              chk_done,
    output logic              chk_mismatch
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic              run;
    logic [IDX_W-1:0]  ld_idx, st_idx, chk_idx;
    logic [3:0]        st_be;
    logic              st_we;
    logic [XLEN-1:0]   st_wdata;
    logic [XLEN-1:0]   ld_word;
    logic [XLEN-1:0]   ld_ext_data, chk_ext_data;
    logic              ld_ext_mis, chk_ext_mis;
    logic              unused_addr_bits;

    assign run          = (state_q == RUN);
    assign init_busy    = (state_q == INIT);
    assign ld_req_ready = run;

    // Word index drops the upper address bits, so addresses wrap.
    assign ld_idx  = ld_req_addr[IDX_W+1:2];
    assign st_idx  = st_addr[IDX_W+1:2];
    assign chk_idx = chk_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{ld_req_addr[ADDR_W-1:IDX_W+2], st_addr[ADDR_W-1:IDX_W+2],
                                chk_addr[ADDR_W-1:IDX_W+2]};

    assign st_be    = store_byte_en(st_funct3, st_addr[1:0]);
    assign st_we    = run && st_valid;
    assign st_wdata = st_data << {st_addr[1:0], 3'b000};

    // State and init counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // INIT walks every word once, then the FSM parks in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = RUN;
            end
            RUN:     ;
            default: state_d = INIT;
        endcase
    end

    // Memory array: init pattern during INIT, byte-enabled committed stores during RUN.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; INIT overwrites every word instead.
        if (!reset) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= XLEN'(cnt_q) + XLEN'(INIT_OFFSET);
            end else if (st_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (st_be[i]) mem[st_idx][8*i +: 8] <= st_wdata[8*i +: 8];
                end
            end
        end
    end

    // Load word with write-first forwarding of a same-cycle store to the same word.
    always_comb begin
        ld_word = mem[ld_idx];
        if (st_we && (st_idx == ld_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) ld_word[8*i +: 8] = st_wdata[8*i +: 8];
            end
        end
    end

    dmem_load_extract #(.XLEN(XLEN)) u_ld_extract (
        .word     (ld_word),
        .lane     (ld_req_addr[1:0]),
        .funct3   (ld_req_funct3),
        .data     (ld_ext_data),
        .misalign (ld_ext_mis)
    );

    // The check reads the pre-store word: it sees memory as committed before this cycle.
    dmem_load_extract #(.XLEN(XLEN)) u_chk_extract (
        .word     (mem[chk_idx]),
        .lane     (chk_addr[1:0]),
        .funct3   (chk_funct3),
        .data     (chk_ext_data),
        .misalign (chk_ext_mis)
    );

    // Registered load response, store-misalign pulse and check result.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_rsp_valid    <= 1'b0;
            ld_rsp_data     <= '0;
            ld_rsp_tag      <= '0;
            ld_rsp_misalign <= 1'b0;
            st_misalign     <= 1'b0;
            chk_done        <= 1'b0;
            chk_mismatch    <= 1'b0;
        end else begin
            ld_rsp_valid <= run && ld_req_valid;
            if (run && ld_req_valid) begin
                ld_rsp_data     <= ld_ext_data;
                ld_rsp_tag      <= ld_req_tag;
                ld_rsp_misalign <= ld_ext_mis;
            end
            st_misalign  <= st_we && store_misalign(st_funct3, st_addr[1:0]);
            chk_done     <= run && chk_valid;
            chk_mismatch <= run && chk_valid && (chk_ext_mis || (chk_ext_data != chk_data));
        end
    end

endmodule

// File: tb/tb_dmem_lsq_port.sv
// Directed scoreboard bench for dmem_lsq_port.
module tb_dmem_lsq_port;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_busy;
    logic        ld_req_valid, ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [2:0]  ld_req_funct3;
    logic [5:0]  ld_req_tag;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic [5:0]  ld_rsp_tag;
    logic        ld_rsp_misalign;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [2:0]  st_funct3;
    logic [31:0] st_data;
    logic        st_misalign;
    logic        chk_valid;
    logic [31:0] chk_addr;
    logic [2:0]  chk_funct3;
    logic [31:0] chk_data;
    logic        chk_done, chk_mismatch;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        mis;
    } ld_exp_t;

    ld_exp_t ld_q[$];
    logic    chk_q[$];
    logic    st_q[$];
    int      total = 0;
    int      bad   = 0;
    logic [5:0] next_tag = 6'd1;

    always #5 clk = ~clk;

    dmem_lsq_port dut (
        .clk(clk), .reset(reset), .init_busy(init_busy),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .ld_req_funct3(ld_req_funct3), .ld_req_tag(ld_req_tag),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_tag(ld_rsp_tag),
        .ld_rsp_misalign(ld_rsp_misalign),
        .st_valid(st_valid), .st_addr(st_addr), .st_funct3(st_funct3), .st_data(st_data),
        .st_misalign(st_misalign),
        .chk_valid(chk_valid), .chk_addr(chk_addr), .chk_funct3(chk_funct3), .chk_data(chk_data),
        .chk_done(chk_done), .chk_mismatch(chk_mismatch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ld_req_valid = 0; ld_req_addr = '0; ld_req_funct3 = '0; ld_req_tag = '0;
        st_valid = 0; st_addr = '0; st_funct3 = '0; st_data = '0;
        chk_valid = 0; chk_addr = '0; chk_funct3 = '0; chk_data = '0;
    endtask

    // Compare outputs against the scoreboard; anything expected must appear this cycle.
    task automatic observe();
        ld_exp_t e;
        logic    m;
        if (ld_q.size() > 0) begin
            e = ld_q.pop_front();
            check("ld_rsp_valid", ld_rsp_valid, 1);
            if (ld_rsp_valid) begin
                check("ld_rsp_tag", ld_rsp_tag, e.tag);
                check("ld_rsp_data", ld_rsp_data, e.data);
                check("ld_rsp_misalign", ld_rsp_misalign, e.mis);
            end
        end else if (ld_rsp_valid) begin
            check("ld_rsp_spurious", ld_rsp_valid, 0);
        end
        if (chk_q.size() > 0) begin
            m = chk_q.pop_front();
            check("chk_done", chk_done, 1);
            if (chk_done) check("chk_mismatch", chk_mismatch, m);
        end else if (chk_done) begin
            check("chk_done_spurious", chk_done, 0);
        end
        if (st_q.size() > 0) begin
            void'(st_q.pop_front());
            check("st_misalign", st_misalign, 1);
        end else if (st_misalign) begin
            check("st_misalign_spurious", st_misalign, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        @(negedge clk);
        observe();
    endtask

    task automatic set_ld(input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, input logic m);
        ld_req_valid = 1; ld_req_addr = a; ld_req_funct3 = f; ld_req_tag = next_tag;
        ld_q.push_back('{tag: next_tag, data: d, mis: m});
        next_tag = next_tag + 6'd1;
    endtask

    task automatic set_st(input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, input logic m);
        st_valid = 1; st_addr = a; st_funct3 = f; st_data = d;
        if (m) st_q.push_back(1'b1);
    endtask

    task automatic set_chk(input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] d, input logic m);
        chk_valid = 1; chk_addr = a; chk_funct3 = f; chk_data = d;
        chk_q.push_back(m);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input logic m);
        set_ld(a, f, d, m); tick(); idle();
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input logic m);
        set_st(a, f, d, m); tick(); idle();
    endtask

    task automatic chk(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input logic m);
        set_chk(a, f, d, m); tick(); idle();
    endtask

    // Count cycles until init_busy drops, with noise on every input that INIT must ignore.
    task automatic wait_init(input string tag);
        int n = 0;
        ld_req_valid = 1; ld_req_addr = 32'h14; ld_req_funct3 = F3_W;
        st_valid = 1; st_addr = 32'h14; st_funct3 = F3_W; st_data = 32'hBAD0BAD0;
        chk_valid = 1; chk_addr = 32'h22; chk_funct3 = F3_W;
        while (init_busy && n < 5000) begin
            tick();
            n++;
        end
        idle();
        check(tag, n, 2048);
        check("ready_after_init", ld_req_ready, 1);
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        reset = 0;
        check("rst_init_busy", init_busy, 1);
        check("rst_ld_req_ready", ld_req_ready, 0);
        check("rst_ld_rsp_valid", ld_rsp_valid, 0);
        check("rst_st_misalign", st_misalign, 0);
        check("rst_chk_done", chk_done, 0);
        check("rst_chk_mismatch", chk_mismatch, 0);
        wait_init("init_cycles");

        // Init pattern, including the last word
        ld(32'h14, F3_W, 32'h0000_0008, 0);
        ld(32'h1FFC, F3_W, 32'h0000_0802, 0);
        ld(32'h20, F3_W, 32'h0000_000B, 0);

        // Commit checks against the init pattern
        chk(32'h14, F3_W, 32'h0000_0008, 0);
        chk(32'h14, F3_W, 32'h0000_0009, 1);

        // Byte store into lane 1, only the low data byte is used
        st(32'h15, F3_B, 32'hAAAA_AAFF, 0);
        ld(32'h14, F3_W,  32'h0000_FF08, 0);
        ld(32'h15, F3_B,  32'hFFFF_FFFF, 0);
        ld(32'h15, F3_BU, 32'h0000_00FF, 0);
        ld(32'h14, F3_H,  32'hFFFF_FF08, 0);
        ld(32'h14, F3_HU, 32'h0000_FF08, 0);
        ld(32'h16, F3_H,  32'h0000_0000, 0);
        ld(32'h14, F3_B,  32'h0000_0008, 0);

        // Write-first forwarding, word and halfword
        set_st(32'h20, F3_W, 32'hDEAD_BEEF, 0);
        set_ld(32'h20, F3_W, 32'hDEAD_BEEF, 0);
        tick(); idle();

        // Misaligned and illegal loads
        ld(32'h13, F3_H,   32'h0, 1);
        ld(32'h16, F3_W,   32'h0, 1);
        ld(32'h14, 3'b011, 32'h0, 0);
        ld(32'h14, 3'b110, 32'h0, 0);

        // Misaligned stores drop and pulse; non-store encodings do nothing
        st(32'h22, F3_W,   32'h1234_5678, 1);
        st(32'h21, F3_H,   32'h0000_5555, 1);
        st(32'h20, 3'b011, 32'h0000_0000, 0);
        st(32'h20, F3_BU,  32'h0000_0000, 0);
        ld(32'h20, F3_W, 32'hDEAD_BEEF, 0);

        st(32'h22, F3_H, 32'hFFFF_CAFE, 0);
        set_st(32'h20, F3_H, 32'h0000_1234, 0);
        set_ld(32'h20, F3_H, 32'h0000_1234, 0);
        tick(); idle();
        ld(32'h20, F3_W, 32'hCAFE_1234, 0);

        // Check sees the pre-store word when a store hits the same cycle
        set_chk(32'h14, F3_W, 32'h0000_FF08, 0);
        set_st(32'h14, F3_W, 32'h1111_1111, 0);
        tick(); idle();
        ld(32'h14, F3_W, 32'h1111_1111, 0);
        chk(32'h13, F3_H,  32'h0000_0000, 1);
        chk(32'h23, F3_B,  32'hFFFF_FFCA, 0);
        chk(32'h22, F3_HU, 32'h0000_CAFE, 0);

        // Address wrap above the index bits
        ld(32'h2014, F3_W, 32'h1111_1111, 0);

        // All three paths in one cycle
        set_st(32'h30, F3_B, 32'h0000_005A, 0);
        set_ld(32'h1FFC, F3_W, 32'h0000_0802, 0);
        set_chk(32'h20, F3_W, 32'hCAFE_1234, 0);
        tick(); idle();
        ld(32'h30, F3_W, 32'h0000_005A, 0);

        // Reset with a load in the same cycle: no response, INIT restarts
        reset = 1;
        ld_req_valid = 1; ld_req_addr = 32'h20; ld_req_funct3 = F3_W;
        tick();
        reset = 0;
        check("rerst_init_busy", init_busy, 1);
        check("rerst_ld_rsp_valid", ld_rsp_valid, 0);
        for (int i = 0; i < 100; i++) tick();
        check("mid_init_busy", init_busy, 1);
        reset = 1;
        tick();
        reset = 0;
        idle();
        check("midrst_init_busy", init_busy, 1);
        wait_init("reinit_cycles");
        ld(32'h20, F3_W, 32'h0000_000B, 0);
        ld(32'h14, F3_W, 32'h0000_0008, 0);

        check("ld_q_drained", ld_q.size(), 0);
        check("chk_q_drained", chk_q.size(), 0);
        check("st_q_drained", st_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
